// File: rtl/alu_acc8.sv
// alu_acc8 -- 8-bit add/subtract unit with a persistent carry flag, for
// multi-byte ADC/SBC chains.
//
// Each operation goes through three phases: IDLE (accept), CALC (one cycle,
// the adder output is registered) and DONE (result held until out_ready).
// The adder is fed only from operand registers loaded at the accept edge, so
// the port values may change freely once a request has been taken.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (IDLE)
//   op[1:0]    in   00 ADD, 01 SUB, 10 ADC, 11 SBC
//   op_a[7:0]  in   operand A
//   op_b[7:0]  in   operand B
//   out_valid  out  result/flags valid (DONE)
//   out_ready  in   downstream takes the result
//   result     out  registered sum/difference
//   flags[3:0] out  {V, N, Z, C}
//
// Configuration
//   ALU_ACC8_OVF_EN  when defined, flags[3] carries the signed-overflow flag;
//                    otherwise flags[3] is tied to 0 and no overflow logic exists.

// Ripple-carry adder with an optional inversion of b (subtract = a + ~b + cin).
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] bx;
  logic [8:0] c;

  assign bx   = b ^ {8{sub}};
  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
  end

  assign cout = c[8];
endmodule

module alu_acc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic [3:0] flags
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;

  // operand registers: the adder sees only these
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       sub_q, sub_d;
  logic       cin_q, cin_d;

  logic [7:0] result_q, result_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       n_q, n_d;

  logic [7:0] sum;
  logic       cout;

  add8 u_add8 (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sub  (sub_q),
    .s    (sum),
    .cout (cout)
  );

`ifdef ALU_ACC8_OVF_EN
  logic v_q, v_d;
  logic v_calc;

  // Overflow: both adder inputs share a sign and the sum's sign differs.
  // The adder input is b after the subtract inversion.
  assign v_calc = (a_q[7] == (b_q[7] ^ sub_q)) && (sum[7] != a_q[7]);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    cin_d     = cin_q;
    result_d  = result_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
`ifdef ALU_ACC8_OVF_EN
    v_d       = v_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d   = op_a;
          b_d   = op_b;
          // op[0] selects subtract; op[1] selects carry-in from the stored C,
          // captured here so the carry used is the one at the accept edge.
          sub_d = op[0];
          cin_d = op[1] ? c_q : op[0];
          state_d = CALC;
        end
      end
      CALC: begin
        result_d = sum;
        c_d      = cout;
        z_d      = (sum == 8'h00);
        n_d      = sum[7];
`ifdef ALU_ACC8_OVF_EN
        v_d      = v_calc;
`endif
        state_d  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      sub_q    <= 1'b0;
      cin_q    <= 1'b0;
      result_q <= 8'h00;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
`ifdef ALU_ACC8_OVF_EN
      v_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
`ifdef ALU_ACC8_OVF_EN
      v_q      <= v_d;
`endif
    end
  end

  assign result = result_q;
`ifdef ALU_ACC8_OVF_EN
  assign flags  = {v_q, n_q, z_q, c_q};
`else
  assign flags  = {1'b0, n_q, z_q, c_q};
`endif
endmodule
